// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: oversamples SCK/CS/MOSI on clk, assembles MSB-first frames,
// publishes good frames with address-decoded write strobes and echoes the last good frame on MISO.
module spi_frame_rx #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned ADDR_BITS   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sck,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  output logic [FRAME_BITS-1:0]     data,
  output logic                      data_rdy,
  output logic [2**ADDR_BITS-1:0]   wr_strobe,
  output logic                      frame_err
);

  localparam int unsigned STROBE_W = 2**ADDR_BITS;
  localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 2);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  logic [1:0]            state_q;
  logic [1:0]            state_nx;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_nx;
  logic [FRAME_BITS-1:0] echo_q;
  logic [FRAME_BITS-1:0] echo_nx;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nx;
  logic                  miso_nx;
  logic                  good_q;
  logic                  good_nx;
  logic                  bad_q;
  logic                  bad_nx;

  // Synchronizers reset low so a chip select held low across reset release never looks idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // Frame FSM; sck edges coinciding with any cs_n edge are dropped.
  always_comb begin
    state_nx = state_q;
    shift_nx = shift_q;
    echo_nx  = echo_q;
    cnt_nx   = cnt_q;
    miso_nx  = 1'b0;
    good_nx  = 1'b0;
    bad_nx   = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (cs_s) state_nx = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          cnt_nx   = '0;
          echo_nx  = data;
          miso_nx  = data[FRAME_BITS-1];
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        miso_nx = miso;
        if (cs_rise) begin
          state_nx = IDLE;
          miso_nx  = 1'b0;
          if (cnt_q == CNT_W'(FRAME_BITS)) good_nx = 1'b1;
          else                             bad_nx  = 1'b1;
        end else if (!cs_fall) begin
          if (sck_rise) begin
            shift_nx = {shift_q[FRAME_BITS-2:0], mosi_s};
            if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_nx = cnt_q + CNT_W'(1);
          end
          if (sck_fall) begin
            echo_nx = {echo_q[FRAME_BITS-2:0], 1'b0};
            miso_nx = echo_q[FRAME_BITS-2];
          end
        end
      end
      default: state_nx = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      shift_q <= '0;
      echo_q  <= '0;
      cnt_q   <= '0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      shift_q <= shift_nx;
      echo_q  <= echo_nx;
      cnt_q   <= cnt_nx;
      miso    <= miso_nx;
      miso_oe <= (state_nx == ACTIVE);
      good_q  <= good_nx;
      bad_q   <= bad_nx;
    end
  end

  // Publish stage: one cycle after the frame verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      data_rdy  <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      data_rdy  <= good_q;
      frame_err <= bad_q;
      if (good_q) begin
        data      <= shift_q;
        wr_strobe <= STROBE_W'(1) << shift_q[FRAME_BITS-1 -: ADDR_BITS];
      end else begin
        wr_strobe <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: SPI master tasks, output monitor and frame scoreboard.
module tb_spi_frame_rx;

  logic        clk;
  logic        rst;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] data;
  logic        data_rdy;
  logic [7:0]  wr_strobe;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_count = 0;
  int err_count = 0;
  int rdy_cyc = 0;
  int err_cyc = 0;
  int cs_cyc = 0;
  int dbl_count = 0;
  int stray_count = 0;
  logic prev_rdy = 1'b0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  spi_frame_rx #(.FRAME_BITS(16), .ADDR_BITS(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .data(data), .data_rdy(data_rdy),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records published frames and pulse timing.
  always @(negedge clk) begin
    if (data_rdy) begin
      obs_q.push_back({data, wr_strobe});
      rdy_cyc = cyc;
      rdy_count++;
      if (prev_rdy) dbl_count++;
    end else if (wr_strobe != 8'h00) begin
      stray_count++;
    end
    if (frame_err) begin
      err_count++;
      err_cyc = cyc;
    end
    prev_rdy = data_rdy;
  end

  task automatic half_sck();
    repeat (4) @(negedge clk);
  endtask

  task automatic push_good(input logic [15:0] v);
    exp_q.push_back({v, 8'(8'(1) << v[15:13])});
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit start, input bit stop,
                           output logic [15:0] miso_word);
    miso_word = '0;
    if (start) cs_n = 1'b0;
    mosi = val[n-1];
    half_sck();
    for (int i = n - 1; i >= 0; i--) begin
      miso_word = {miso_word[14:0], miso};
      sck = 1'b1;
      half_sck();
      sck = 1'b0;
      if (i > 0) mosi = val[i-1];
      half_sck();
    end
    if (stop) begin
      cs_n   = 1'b1;
      cs_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, miso_oe, data, data_rdy, wr_strobe, frame_err} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: observed %h required 0", {miso, miso_oe, data, data_rdy, wr_strobe, frame_err});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] mw;
    logic [23:0] e;
    logic [23:0] o;
    int r0 = rdy_count;
    int e0 = err_count;
    push_good(16'h2080);
    send_bits(32'h2080, 16, 1'b1, 1'b1, mw);
    repeat (12) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL basic_frame: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL basic_frame: observed %h required %h", o, e); end
      end
    end
    checks++;
    if (rdy_count - r0 != 1) begin errors++; $display("FAIL basic_rdy_count: observed %0d required 1", rdy_count - r0); end
    checks++;
    if (err_count != e0) begin errors++; $display("FAIL basic_frame_err: observed %0d required 0", err_count - e0); end
    checks++;
    if (rdy_cyc - cs_cyc != 4) begin errors++; $display("FAIL basic_latency: observed %0d required 4", rdy_cyc - cs_cyc); end
    checks++;
    if (data !== 16'h2080) begin errors++; $display("FAIL basic_data_hold: observed %h required 2080", data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mw;
    logic [23:0] e;
    logic [23:0] o;
    int r0 = rdy_count;
    push_good(16'hE0FF);
    send_bits(32'hE0FF, 16, 1'b1, 1'b1, mw);
    half_sck(); half_sck();
    push_good(16'h0000);
    send_bits(32'h0000, 16, 1'b1, 1'b1, mw);
    repeat (12) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_frame: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_frame: observed %h required %h", o, e); end
      end
    end
    checks++;
    if (rdy_count - r0 != 2) begin errors++; $display("FAIL b2b_rdy_count: observed %0d required 2", rdy_count - r0); end
    checks++;
    if (data !== 16'h0000) begin errors++; $display("FAIL b2b_data: observed %h required 0000", data); end
  endtask

  task automatic test_bad_length();
    logic [15:0] mw;
    int r0 = rdy_count;
    int e0 = err_count;
    send_bits(32'h7FFF, 15, 1'b1, 1'b1, mw);
    half_sck(); half_sck();
    send_bits(32'h1FFFF, 17, 1'b1, 1'b1, mw);
    repeat (12) @(negedge clk);
    checks++;
    if (err_count - e0 != 2) begin errors++; $display("FAIL bad_len_err_count: observed %0d required 2", err_count - e0); end
    checks++;
    if (rdy_count != r0) begin errors++; $display("FAIL bad_len_rdy: observed %0d required 0", rdy_count - r0); end
    checks++;
    if (err_cyc - cs_cyc != 4) begin errors++; $display("FAIL bad_len_latency: observed %0d required 4", err_cyc - cs_cyc); end
    checks++;
    if (data !== 16'h0000) begin errors++; $display("FAIL bad_len_data: observed %h required 0000", data); end
  endtask

  task automatic test_miso_echo();
    logic [15:0] mw;
    logic [23:0] e;
    logic [23:0] o;
    push_good(16'hA5C3);
    send_bits(32'hA5C3, 16, 1'b1, 1'b1, mw);
    half_sck(); half_sck();
    checks++;
    if ({miso_oe, miso} !== 2'b00) begin errors++; $display("FAIL miso_idle: observed %b required 00", {miso_oe, miso}); end
    push_good(16'h1234);
    send_bits(32'h1234, 16, 1'b1, 1'b1, mw);
    checks++;
    if (mw !== 16'hA5C3) begin errors++; $display("FAIL miso_echo: observed %h required a5c3", mw); end
    repeat (12) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL miso_frame: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL miso_frame: observed %h required %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] mw;
    logic [23:0] e;
    logic [23:0] o;
    int r0 = rdy_count;
    int e0 = err_count;
    send_bits(32'h5A5A, 16, 1'b1, 1'b0, mw);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_bits(32'h5A5A, 7, 1'b1, 1'b0, mw);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (data !== 16'h0000) begin errors++; $display("FAIL midrst_clear: observed %h required 0000", data); end
    rst = 1'b0;
    send_bits(32'h01FF, 9, 1'b0, 1'b1, mw);
    repeat (12) @(negedge clk);
    checks++;
    if ((rdy_count != r0) || (err_count != e0)) begin
      errors++;
      $display("FAIL midrst_pulses: observed rdy %0d err %0d required 0 0", rdy_count - r0, err_count - e0);
    end
    half_sck();
    push_good(16'h4011);
    send_bits(32'h4011, 16, 1'b1, 1'b1, mw);
    repeat (12) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL midrst_frame: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL midrst_frame: observed %h required %h", o, e); end
      end
    end
    checks++;
    if (data !== 16'h4011) begin errors++; $display("FAIL midrst_data: observed %h required 4011", data); end
  endtask

  task automatic test_sck_idle();
    logic [15:0] mw;
    logic [23:0] e;
    logic [23:0] o;
    int r0 = rdy_count;
    int e0 = err_count;
    for (int i = 0; i < 20; i++) begin
      sck = 1'b1;
      half_sck();
      sck = 1'b0;
      half_sck();
    end
    repeat (8) @(negedge clk);
    checks++;
    if ((rdy_count != r0) || (err_count != e0) || (miso_oe !== 1'b0)) begin
      errors++;
      $display("FAIL idle_sck: observed rdy %0d err %0d oe %b required 0 0 0", rdy_count - r0, err_count - e0, miso_oe);
    end
    push_good(16'h6001);
    send_bits(32'h6001, 16, 1'b1, 1'b1, mw);
    repeat (12) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL idle_frame: observed none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL idle_frame: observed %h required %h", o, e); end
      end
    end
    checks++;
    if (data !== 16'h6001) begin errors++; $display("FAIL idle_data: observed %h required 6001", data); end
  endtask

  task automatic test_end();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL extra_frames: observed %0d required 0", obs_q.size()); end
    checks++;
    if (dbl_count != 0) begin errors++; $display("FAIL rdy_width: observed %0d long pulses required 0", dbl_count); end
    checks++;
    if (stray_count != 0) begin errors++; $display("FAIL stray_strobe: observed %0d required 0", stray_count); end
  endtask

  initial begin
    rst  = 1'b1;
    sck  = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_length();
    test_miso_echo();
    test_reset_mid_frame();
    test_sck_idle();
    test_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Clock-domain SPI slave front end that feeds the PWM register bank.
- Oversamples SCK/CS/MOSI on the system clock and assembles 16-bit MSB-first frames.
- Validates bit count, publishes each good frame with a one-cycle data_rdy pulse, and decodes address bits [15:13] into one-hot single-cycle write strobes.
- Echoes the previous good frame on MISO.

Parameters:
- FRAME_BITS, 16, bits per valid frame.
- ADDR_BITS, 3, address field width at data[FRAME_BITS-1 -: ADDR_BITS]; strobe vector is 2**ADDR_BITS wide.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCK frequency.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock, mode 0, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out (echo of the last good frame).
- miso_oe  out  1  high while the synchronized cs_n is low.
- data  out  FRAME_BITS  last valid frame; held between frames.
- data_rdy  out  1  one-cycle pulse when data updates.
- wr_strobe  out  2**ADDR_BITS  one-hot pulse coincident with data_rdy.
- frame_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset: all outputs 0. Shift register, bit counter and echo register are 0. State is WAIT_IDLE.
- Sync: sck, cs_n and mosi each pass through SYNC_STAGES FFs. Edges are detected by comparing the last sync stage with a one-cycle-delayed copy.
- States:
  - WAIT_IDLE: leave only when synchronized cs_n is high, then go to IDLE. This stops a frame already in progress at reset release from being accepted.
  - IDLE: on cs_n fall, clear the counter, load the echo shifter from data, go to ACTIVE.
  - ACTIVE, sck rise: shift synchronized mosi into the LSB (MSB-first framing). Counter increments and saturates at FRAME_BITS+1.
  - ACTIVE, sck fall: echo shifter shifts left; miso = echo[FRAME_BITS-1].
  - ACTIVE, cs_n rise: go to IDLE. If counter == FRAME_BITS, the frame is good; otherwise it is rejected.
- Simultaneous events: an sck edge detected in the same cycle as a cs_n edge (either direction) is discarded. sck edges outside ACTIVE are ignored.
- Latency: if cs_n rise is first sampled at clk edge N, data, data_rdy and wr_strobe change at edge N+SYNC_STAGES+1.
  - data_rdy and wr_strobe are high for exactly one cycle.
  - wr_strobe bit k is set where k = data[FRAME_BITS-1 -: ADDR_BITS].
  - data stays stable until the next good frame.
- Rejected frame (counter < FRAME_BITS or counter > FRAME_BITS): frame_err pulses at the same latency. data, data_rdy and wr_strobe are unchanged/low.
- Counter saturation means frames of any length above FRAME_BITS are rejected, with no wrap-around.
- miso: 0 and miso_oe 0 outside ACTIVE. The first echoed bit (echo MSB) is driven from the cs_n fall.
- Reset mid-frame: everything clears immediately (asynchronous). The remaining bits of that frame produce no data_rdy and no frame_err.
- Back-to-back frames with one SCK period of cs_n high between them must both be accepted at clk = 8x SCK.

Test Plan:
- Send 16-bit frame 0x2080 -> data=0x2080, one data_rdy pulse, wr_strobe=0x02, frame_err=0, pulse at N+3 for SYNC_STAGES=2.
- Send frame 0xE0FF, then frame 0x0000 -> wr_strobe=0x80 then 0x01; data ends at 0x0000; exactly two data_rdy pulses.
- Send a 15-bit and then a 17-bit frame -> frame_err pulses twice, data keeps its previous value, wr_strobe stays 0.
- Send 0xA5C3, then a second frame while sampling miso on sck rise -> captured miso word = 0xA5C3; miso_oe low between frames.
- Assert rst after 7 bits with cs_n held low, release it, clock in the 9 remaining bits, raise cs_n, then send 0x4011 -> no pulse for the broken frame; second frame gives data=0x4011, wr_strobe=0x04.
- Toggle sck 20 times with cs_n high, then send 0x6001 -> sck activity ignored; data=0x6001, wr_strobe=0x08.
